// File: rtl/mem_access_unit.sv
// Memory-stage initiator for the data-memory SRAM-like port.
// Decodes a pipeline load/store into size, byte enables and replicated write
// data, runs the req/addr_ok/data_ok handshake and hands raw read data plus
// the lane mask to the write-back stage.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no op in flight; decode and latch a new op on mem_valid
// REQ   | data_req asserted, holding request until data_addr_ok
// WAIT  | request accepted, waiting for data_data_ok
// DONE  | result/exception presented to WB until wb_ready
module mem_access_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_wr,
  input  logic [2:0]  mem_lw_sw_type,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_store_val,
  input  logic        wb_ready,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [3:0]  dmm_byte_enable,
  output logic [31:0] dmm_load_val,
  output logic        mem_stall,
  output logic        mem_complete,
  output logic        mem_adel,
  output logic        mem_ades
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state;
  logic [3:0]  be_c;
  logic [1:0]  size_c;
  logic [31:0] wdata_c;
  logic        mis_c;

  // Decode type/address into size, lane mask, alignment and write data.
  // Illegal types are flagged as misaligned so they never reach the bus.
  always_comb begin
    be_c    = 4'b0000;
    size_c  = 2'd2;
    mis_c   = 1'b0;
    wdata_c = 32'h0;
    case (mem_lw_sw_type)
      3'b000, 3'b001: begin
        size_c = 2'd0;
        be_c   = 4'b0001 << mem_addr[1:0];
      end
      3'b010, 3'b011: begin
        size_c = 2'd1;
        be_c   = mem_addr[1] ? 4'b1100 : 4'b0011;
        mis_c  = mem_addr[0];
      end
      3'b100: begin
        size_c = 2'd2;
        be_c   = 4'b1111;
        mis_c  = |mem_addr[1:0];
      end
      default: begin
        size_c = 2'd2;
        be_c   = 4'b0000;
        mis_c  = 1'b1;
      end
    endcase
    if (mem_wr) begin
      case (size_c)
        2'd0:    wdata_c = {4{mem_store_val[7:0]}};
        2'd1:    wdata_c = {2{mem_store_val[15:0]}};
        default: wdata_c = mem_store_val;
      endcase
    end
  end

  // Transaction FSM; all bus and WB-facing outputs are registered here.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state           <= S_IDLE;
      data_req        <= 1'b0;
      data_wr         <= 1'b0;
      data_size       <= 2'd0;
      data_addr       <= 32'h0;
      data_wdata      <= 32'h0;
      dmm_byte_enable <= 4'b0000;
      dmm_load_val    <= 32'h0;
      mem_complete    <= 1'b0;
      mem_adel        <= 1'b0;
      mem_ades        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mem_valid) begin
            data_addr       <= mem_addr;
            data_wr         <= mem_wr;
            data_size       <= size_c;
            data_wdata      <= wdata_c;
            dmm_byte_enable <= be_c;
            if (mis_c) begin
              state        <= S_DONE;
              mem_complete <= 1'b1;
              mem_adel     <= ~mem_wr;
              mem_ades     <= mem_wr;
            end else begin
              state    <= S_REQ;
              data_req <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (data_addr_ok) begin
            data_req <= 1'b0;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (data_data_ok) begin
            dmm_load_val <= data_rdata;
            mem_complete <= 1'b1;
            state        <= S_DONE;
          end
        end
        S_DONE: begin
          if (wb_ready) begin
            mem_complete <= 1'b0;
            mem_adel     <= 1'b0;
            mem_ades     <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Hold upstream while an op is present but not yet presented to WB.
  assign mem_stall = mem_valid && (state != S_DONE);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: the stimulus task pushes expected bus
// requests and WB results into queues; negedge monitors pop and compare.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_valid;
  logic        mem_wr;
  logic [2:0]  mem_lw_sw_type;
  logic [31:0] mem_addr;
  logic [31:0] mem_store_val;
  logic        wb_ready;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic [3:0]  dmm_byte_enable;
  logic [31:0] dmm_load_val;
  logic        mem_stall;
  logic        mem_complete;
  logic        mem_adel;
  logic        mem_ades;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic        chk_be;
    logic [3:0]  be;
    logic        chk_val;
    logic [31:0] val;
    logic        adel;
    logic        ades;
  } rsp_t;

  req_t reqq[$];
  rsp_t rspq[$];
  req_t rq;
  rsp_t rs;

  mem_access_unit dut (
    .clk             (clk),
    .resetn          (resetn),
    .mem_valid       (mem_valid),
    .mem_wr          (mem_wr),
    .mem_lw_sw_type  (mem_lw_sw_type),
    .mem_addr        (mem_addr),
    .mem_store_val   (mem_store_val),
    .wb_ready        (wb_ready),
    .data_req        (data_req),
    .data_wr         (data_wr),
    .data_size       (data_size),
    .data_addr       (data_addr),
    .data_wdata      (data_wdata),
    .data_addr_ok    (data_addr_ok),
    .data_data_ok    (data_data_ok),
    .data_rdata      (data_rdata),
    .dmm_byte_enable (dmm_byte_enable),
    .dmm_load_val    (dmm_load_val),
    .mem_stall       (mem_stall),
    .mem_complete    (mem_complete),
    .mem_adel        (mem_adel),
    .mem_ades        (mem_ades)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bus monitor: every accepted request must match the oldest expectation.
  always @(negedge clk) begin
    if (resetn && data_req) begin
      if (reqq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_req: got data_req=1 addr %h expected no request", data_addr);
      end else if (data_addr_ok) begin
        rq = reqq.pop_front();
        chk("req_wr", data_wr, rq.wr);
        chk("req_size", data_size, rq.size);
        chk("req_addr", data_addr, rq.addr);
        chk("req_wdata", data_wdata, rq.wdata);
      end
    end
  end

  // WB monitor: every result handed over must match the oldest expectation.
  always @(negedge clk) begin
    if (resetn && mem_complete && wb_ready) begin
      if (rspq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_complete: got mem_complete=1 expected none");
      end else begin
        rs = rspq.pop_front();
        if (rs.chk_be) chk("rsp_be", dmm_byte_enable, rs.be);
        if (rs.chk_val) chk("rsp_load_val", dmm_load_val, rs.val);
        chk("rsp_adel", mem_adel, rs.adel);
        chk("rsp_ades", mem_ades, rs.ades);
      end
    end
  end

  // One op: ad = addr_ok wait cycles, dd = data_ok wait after acceptance,
  // wd = cycles wb_ready stays low while DONE.
  task automatic do_op(input logic wr, input logic [2:0] ty, input logic [31:0] addr,
                       input logic [31:0] val, input int ad, input int dd,
                       input logic [31:0] rd, input int wd, input logic mis,
                       input logic [3:0] ebe, input logic [1:0] esize,
                       input logic [31:0] ewdata);
    req_t r;
    rsp_t p;
    r.wr = wr; r.size = esize; r.addr = addr; r.wdata = ewdata;
    p.chk_be = !mis; p.be = ebe; p.chk_val = !wr && !mis; p.val = rd;
    p.adel = mis && !wr; p.ades = mis && wr;
    if (!mis) reqq.push_back(r);
    rspq.push_back(p);
    tick();
    mem_valid = 1'b1; mem_wr = wr; mem_lw_sw_type = ty;
    mem_addr = addr; mem_store_val = val;
    @(negedge clk);
    chk("stall_issue", mem_stall, 1'b1);
    chk("req_early", data_req, 1'b0);
    tick();
    if (!mis) begin
      for (int i = 0; i <= ad; i++) begin
        data_addr_ok = (i == ad);
        @(negedge clk);
        chk("req_held", data_req, 1'b1);
        chk("req_addr_stable", data_addr, addr);
        chk("req_size_stable", data_size, esize);
        chk("stall_req", mem_stall, 1'b1);
        tick();
      end
      data_addr_ok = 1'b0;
      for (int i = 0; i <= dd; i++) begin
        data_data_ok = (i == dd);
        data_rdata   = (i == dd) ? rd : 32'h0;
        @(negedge clk);
        chk("req_dropped", data_req, 1'b0);
        chk("stall_wait", mem_stall, 1'b1);
        tick();
      end
      data_data_ok = 1'b0;
      data_rdata   = 32'h0;
    end
    for (int i = 0; i <= wd; i++) begin
      wb_ready = (i == wd);
      @(negedge clk);
      chk("complete_on_time", mem_complete, 1'b1);
      chk("stall_done", mem_stall, 1'b0);
      if (!wr && !mis) chk("load_val_held", dmm_load_val, rd);
      tick();
    end
    wb_ready  = 1'b0;
    mem_valid = 1'b0;
    @(negedge clk);
    chk("complete_cleared", mem_complete, 1'b0);
    chk("adel_cleared", mem_adel, 1'b0);
    chk("ades_cleared", mem_ades, 1'b0);
  endtask

  initial begin
    resetn = 1'b0; mem_valid = 1'b0; mem_wr = 1'b0; mem_lw_sw_type = 3'b000;
    mem_addr = 32'h0; mem_store_val = 32'h0; wb_ready = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    repeat (3) tick();
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_req", data_req, 1'b0);
    chk("rst_complete", mem_complete, 1'b0);
    chk("rst_adel", mem_adel, 1'b0);
    chk("rst_ades", mem_ades, 1'b0);
    chk("rst_be", dmm_byte_enable, 4'b0000);
    chk("rst_load_val", dmm_load_val, 32'h0);
    chk("rst_addr", data_addr, 32'h0);
    chk("rst_wdata", data_wdata, 32'h0);
    chk("rst_stall", mem_stall, 1'b0);

    //     wr    type    addr          val           ad dd rdata         wd mis   be       sz    wdata
    do_op(1'b1, 3'b100, 32'h1000_0004, 32'hDEAD_BEEF, 0, 0, 32'h0,        0, 1'b0, 4'b1111, 2'd2, 32'hDEAD_BEEF);
    do_op(1'b1, 3'b000, 32'h1000_0003, 32'h0000_00A5, 0, 0, 32'h0,        0, 1'b0, 4'b1000, 2'd0, 32'hA5A5_A5A5);
    do_op(1'b1, 3'b010, 32'h1000_0002, 32'h0000_1234, 0, 0, 32'h0,        0, 1'b0, 4'b1100, 2'd1, 32'h1234_1234);
    do_op(1'b0, 3'b010, 32'h1000_0001, 32'h0,         0, 0, 32'h0,        0, 1'b1, 4'b0000, 2'd1, 32'h0);
    do_op(1'b1, 3'b100, 32'h1000_0002, 32'h1111_2222, 0, 0, 32'h0,        0, 1'b1, 4'b0000, 2'd2, 32'h0);
    do_op(1'b0, 3'b001, 32'h1000_0001, 32'h0,         1, 0, 32'h1122_3344, 0, 1'b0, 4'b0010, 2'd0, 32'h0);
    do_op(1'b0, 3'b011, 32'h1000_0002, 32'hFFFF_FFFF, 0, 1, 32'h5566_7788, 1, 1'b0, 4'b1100, 2'd1, 32'h0);
    do_op(1'b0, 3'b101, 32'h1000_0000, 32'h0,         0, 0, 32'h0,        0, 1'b1, 4'b0000, 2'd2, 32'h0);
    do_op(1'b1, 3'b000, 32'h0000_0002, 32'hFFFF_FF5A, 0, 0, 32'h0,        0, 1'b0, 4'b0100, 2'd0, 32'h5A5A_5A5A);
    do_op(1'b1, 3'b100, 32'h0000_0001, 32'h0,         0, 0, 32'h0,        0, 1'b1, 4'b0000, 2'd2, 32'h0);
    do_op(1'b0, 3'b100, 32'h1000_0008, 32'h0,         3, 2, 32'h80FF_7F01, 2, 1'b0, 4'b1111, 2'd2, 32'h0);

    // Reset while WAITing: must drop to IDLE, clear results, ignore late data_ok.
    rq.wr = 1'b0; rq.size = 2'd2; rq.addr = 32'h1000_0010; rq.wdata = 32'h0;
    reqq.push_back(rq);
    tick();
    mem_valid = 1'b1; mem_wr = 1'b0; mem_lw_sw_type = 3'b100; mem_addr = 32'h1000_0010;
    @(negedge clk);
    tick();
    data_addr_ok = 1'b1;
    @(negedge clk);
    tick();
    data_addr_ok = 1'b0;
    resetn = 1'b0;
    mem_valid = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("midrst_req", data_req, 1'b0);
    chk("midrst_complete", mem_complete, 1'b0);
    chk("midrst_load_val", dmm_load_val, 32'h0);
    chk("midrst_be", dmm_byte_enable, 4'b0000);
    chk("midrst_addr", data_addr, 32'h0);
    resetn = 1'b1;
    data_data_ok = 1'b1;
    data_rdata = 32'hCAFE_F00D;
    wb_ready = 1'b1;
    tick();
    data_data_ok = 1'b0;
    data_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("late_dataok_complete", mem_complete, 1'b0);
      chk("late_dataok_load_val", dmm_load_val, 32'h0);
      chk("late_dataok_req", data_req, 1'b0);
      tick();
    end
    wb_ready = 1'b0;

    chk("reqq_drained", reqq.size(), 0);
    chk("rspq_drained", rspq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage initiator for the data-memory SRAM-like port; the store/request side paired with the write-back load extractor.
- Converts a pipeline load/store (type, address, store value) into byte enables, size and replicated write data, and runs the req/addr_ok/data_ok handshake.
- Returns raw 32-bit read data plus the byte-enable pattern the write-back stage uses for lb/lbu/lh/lhu/lw extraction.
- Stalls the pipeline while a transaction is outstanding.

Parameters:
- none

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- mem_valid  in  1  memory op present in MEM stage; held stable until mem_complete
- mem_wr  in  1  1=store, 0=load
- mem_lw_sw_type  in  3  000 lb/sb, 001 lbu, 010 lh/sh, 011 lhu, 100 lw/sw, others illegal
- mem_addr  in  32  byte address
- mem_store_val  in  32  register value to store (low bits significant)
- wb_ready  in  1  downstream accepts result this cycle
- data_req  out  1  request valid
- data_wr  out  1  request is write
- data_size  out  2  0 byte, 1 half, 2 word
- data_addr  out  32  request address, unmodified byte address
- data_wdata  out  32  replicated store data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  read data valid / write done
- data_rdata  in  32  read data
- dmm_byte_enable  out  4  lane mask to WB
- dmm_load_val  out  32  latched data_rdata
- mem_stall  out  1  hold upstream
- mem_complete  out  1  result valid to WB
- mem_adel  out  1  misaligned load
- mem_ades  out  1  misaligned store

Behaviour:
- Reset (resetn=0 at posedge): state=IDLE; data_req, mem_complete, mem_adel, mem_ades = 0; dmm_byte_enable=0; dmm_load_val=0; data_addr/data_wdata=0.
- Byte enable from type and addr[1:0]:
  - byte types: 00→0001, 01→0010, 10→0100, 11→1000.
  - half types: 00→0011, 10→1100.
  - lw/sw: 00→1111.
- Misalignment: half with addr[0]=1, or word with addr[1:0]≠0, is misaligned. An illegal type is treated as misaligned.
- Write data:
  - sb: {4{val[7:0]}}
  - sh: {2{val[15:0]}}
  - sw: val
  - loads: data_wdata=0.
- States:
  - IDLE: on mem_valid, latch addr/wr/size/wdata/byte_enable.
    - If aligned → REQ; data_req=1 from the next cycle (registered, 1-cycle issue latency).
    - If misaligned → DONE with mem_adel (load) or mem_ades (store) set; no bus request.
  - REQ: data_req held with stable addr/wr/size/wdata until data_addr_ok=1 at a clock edge, then → WAIT. data_req drops the cycle after acceptance.
  - WAIT: on data_data_ok=1, latch data_rdata into dmm_load_val (stores latch too; value is don't-care) → DONE.
  - DONE: mem_complete=1; dmm_byte_enable, dmm_load_val and exception flags held.
    - If wb_ready=1 → IDLE.
    - On leaving DONE, clear mem_complete, adel and ades.
- data_data_ok is sampled only in WAIT; an assertion in IDLE/REQ/DONE is ignored.
- mem_stall = mem_valid && state≠DONE, combinational.
- Minimum latency with addr_ok and data_ok each zero-wait: mem_valid@N, req@N+1, accepted@N+1, data_ok@N+2, complete@N+3.
- Reset mid-transaction (any state): return to IDLE next edge, data_req deasserted, latched results cleared, no mem_complete pulse.
- Back-to-back operations: a new op is taken only from IDLE, so there is at least one idle cycle between completions.

Test Plan:
- sw, addr 0x1000_0004, val 0xDEADBEEF, addr_ok/data_ok zero-wait → req@N+1: size=2, wdata 0xDEADBEEF, byte_enable 1111; mem_complete@N+3; stall high N..N+2.
- sb addr 0x…3, val 0x000000A5 → wdata 0xA5A5A5A5, size=0, byte_enable 1000; sh addr 0x…2, val 0x1234 → wdata 0x12341234, byte_enable 1100.
- lh addr 0x…1 → no data_req ever, mem_adel=1 and mem_complete=1 at N+1; sw addr 0x…2 → mem_ades=1.
- lw with addr_ok delayed 3 cycles, data_ok 2 cycles after acceptance, rdata 0x80FF7F01 → req, addr, size stable throughout wait; dmm_load_val=0x80FF7F01 held while wb_ready=0 for 2 cycles, released when wb_ready=1.
- resetn low during WAIT → IDLE next edge, data_req=0, late data_ok ignored, no mem_complete.
